fp_stream_accumulator: RTL and testbench

- Sequential controller that sums a packet of floating-point values by driving the team's combinational floating-point adder and capturing its sum.
- Sits directly around the adder:
  - Upstream side: feeds the adder's a, b and selector inputs.
  - Downstream side: consumes the adder's sum.
- Adds what the adder lacks: valid/ready handshakes, packet framing, a registered accumulator, zero-operand bypass and exact-cancellation handling.

---
 rtl/fp_acc_pkg.sv | 35 +++
 rtl/fp_stream_accumulator_if.sv | 28 ++
 rtl/fp_stream_accumulator.sv | 107 ++++++++++
 tb/tb_fp_stream_accumulator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_acc_pkg.sv
// Shared state encoding, IEEE field positions and operand classification helpers
// for the floating-point stream accumulator.
package fp_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACC, ADD, OUT} state_t;

  localparam int unsigned SP_SIGN   = 31;
  localparam int unsigned SP_EXP_HI = 30;
  localparam int unsigned SP_EXP_LO = 23;
  localparam int unsigned SP_MAN_HI = 22;
  localparam int unsigned SP_MAN_LO = 0;

  localparam int unsigned HP_SIGN   = 15;
  localparam int unsigned HP_EXP_HI = 14;
  localparam int unsigned HP_EXP_LO = 10;
  localparam int unsigned HP_MAN_HI = 9;
  localparam int unsigned HP_MAN_LO = 0;

  // Denormals share the all-zero exponent and are therefore treated as +0.
  function automatic logic is_zero(input logic [31:0] data, input logic half);
    if (half) return (data[HP_EXP_HI:HP_EXP_LO] == '0);
    else      return (data[SP_EXP_HI:SP_EXP_LO] == '0);
  endfunction

  function automatic logic is_cancel(input logic [31:0] a, input logic [31:0] b,
                                     input logic half);
    if (half)
      return (a[HP_SIGN] != b[HP_SIGN]) &&
             (a[HP_EXP_HI:HP_MAN_LO] == b[HP_EXP_HI:HP_MAN_LO]);
    else
      return (a[SP_SIGN] != b[SP_SIGN]) &&
             (a[SP_EXP_HI:SP_MAN_LO] == b[SP_EXP_HI:SP_MAN_LO]);
  endfunction

endpackage

// File: rtl/fp_stream_accumulator_if.sv
// Element stream, result stream and adder-side signals of the accumulator.
interface fp_stream_accumulator_if #(
  parameter int unsigned CNT_W = 16
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_sel;
  logic [31:0]      add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  mode, in_valid, in_data, in_last, add_sum, out_ready,
    output in_ready, add_a, add_b, add_sel, out_valid, out_data, out_count
  );

  modport master (
    output mode, in_valid, in_data, in_last, add_sum, out_ready,
    input  in_ready, add_a, add_b, add_sel, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_stream_accumulator.sv
// Packet accumulator wrapped around an external combinational FP adder:
// handshakes, framing, zero bypass and exact-cancellation handling.
module fp_stream_accumulator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_stream_accumulator_if.slave  bus
);
  import fp_acc_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_acc, w_acc_nxt;
  logic [31:0]      r_add_a, w_add_a_nxt;
  logic [31:0]      r_add_b, w_add_b_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;

  logic             w_fmt;
  logic [31:0]      w_din;
  logic [31:0]      w_sum;
  logic             w_in_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_count_inc;

  // Precision comes from the live mode pin only for the packet's first element.
  assign w_fmt       = (r_state == IDLE) ? bus.mode : r_mode;
  assign w_din       = w_fmt ? {16'h0000, bus.in_data[15:0]} : bus.in_data;
  assign w_sum       = r_mode ? {16'h0000, bus.add_sum[15:0]} : bus.add_sum;
  assign w_in_ready  = ~rst & ((r_state == IDLE) | (r_state == ACC));
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_mode  <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_add_a <= w_add_a_nxt;
      r_add_b <= w_add_b_nxt;
      r_mode  <= w_mode_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_add_a_nxt = r_add_a;
    w_add_b_nxt = r_add_b;
    w_mode_nxt  = r_mode;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_din;
          w_mode_nxt  = bus.mode;
          w_count_nxt = CNT_W'(1);
          w_state_nxt = bus.in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          if (is_zero(w_din, r_mode)) begin
            w_state_nxt = bus.in_last ? OUT : ACC;
          end else if (is_zero(r_acc, r_mode)) begin
            w_acc_nxt   = w_din;
            w_state_nxt = bus.in_last ? OUT : ACC;
          end else begin
            w_add_a_nxt = r_acc;
            w_add_b_nxt = w_din;
            w_last_nxt  = bus.in_last;
            w_state_nxt = ADD;
          end
        end
      end
      ADD: begin
        w_acc_nxt   = is_cancel(r_add_a, r_add_b, r_mode) ? '0 : w_sum;
        w_state_nxt = r_last ? OUT : ACC;
      end
      OUT: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_sel   = r_mode;
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = (r_state == OUT) ? r_acc : '0;
  assign bus.out_count = (r_state == OUT) ? r_count : '0;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench: accumulator plus a same-sign truncating adder model.
module tb_fp_stream_accumulator;

  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_add;
  int unsigned lat;

  fp_stream_accumulator_if #(.CNT_W(16)) bus ();

  fp_stream_accumulator #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only same-sign addition is modelled; mixed signs must never reach the sum.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b,
                                       input logic half);
    int mw, ew;
    logic [63:0] ea, eb, ma, mb, s, t;
    logic sa, sb;
    mw = half ? 10 : 23;
    ew = half ? 5 : 8;
    sa = a[mw+ew];
    sb = b[mw+ew];
    if (sa != sb) return 32'hDEAD_BEEF;
    ea = (64'(a) >> mw) & ((64'd1 << ew) - 64'd1);
    eb = (64'(b) >> mw) & ((64'd1 << ew) - 64'd1);
    ma = (64'(a) & ((64'd1 << mw) - 64'd1)) | (64'd1 << mw);
    mb = (64'(b) & ((64'd1 << mw) - 64'd1)) | (64'd1 << mw);
    if (ea < eb) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
    end
    mb = mb >> (ea - eb);
    s  = ma + mb;
    if ((s >> (mw + 1)) != 64'd0) begin
      s  = s >> 1;
      ea = ea + 64'd1;
    end
    t = (64'(sa) << (mw + ew)) | (ea << mw) | (s & ((64'd1 << mw) - 64'd1));
    return t[31:0];
  endfunction

  always_comb bus.add_sum = fadd(bus.add_a, bus.add_b, bus.add_sel);

  // Outside reset, in_ready low with no result pending identifies the ADD cycle.
  always @(negedge clk)
    if (!rst && !bus.in_ready && !bus.out_valid) n_add++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic m);
    int unsigned n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.mode     = m;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out(output int unsigned n);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_add = 0;
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_add_b", 64'(bus.add_b), 64'd0);
    chk("rst_add_sel", 64'(bus.add_sel), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // single precision 1 + 2 + 1
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    chk("sp_add_in_ready", 64'(bus.in_ready), 64'd0);
    chk("sp_add_a", 64'(bus.add_a), 64'h3F80_0000);
    chk("sp_add_b", 64'(bus.add_b), 64'h4000_0000);
    chk("sp_add_sel", 64'(bus.add_sel), 64'd0);
    send(32'h3F80_0000, 1'b1, 1'b0);
    wait_out(lat);
    chk("sp_latency", 64'(lat), 64'd1);
    chk("sp_data", 64'(bus.out_data), 64'h4080_0000);
    chk("sp_count", 64'(bus.out_count), 64'd3);
    tick();
    chk("sp_valid_drop", 64'(bus.out_valid), 64'd0);

    // half precision 1 + 1 with junk upper bits
    send(32'hFFFF_3C00, 1'b0, 1'b1);
    send(32'hFFFF_3C00, 1'b1, 1'b1);
    chk("hp_add_sel", 64'(bus.add_sel), 64'd1);
    chk("hp_add_a", 64'(bus.add_a), 64'h0000_3C00);
    chk("hp_add_b", 64'(bus.add_b), 64'h0000_3C00);
    wait_out(lat);
    chk("hp_latency", 64'(lat), 64'd1);
    chk("hp_data", 64'(bus.out_data), 64'h0000_4000);
    chk("hp_count", 64'(bus.out_count), 64'd2);
    tick();

    // zero bypass
    n_add = 0;
    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0);
    wait_out(lat);
    chk("zb_latency", 64'(lat), 64'd0);
    chk("zb_data", 64'(bus.out_data), 64'h3F80_0000);
    chk("zb_count", 64'(bus.out_count), 64'd3);
    chk("zb_no_add", 64'(n_add), 64'd0);
    tick();

    // exact cancellation 3 + -3
    send(32'h4040_0000, 1'b0, 1'b0);
    send(32'hC040_0000, 1'b1, 1'b0);
    wait_out(lat);
    chk("cx_latency", 64'(lat), 64'd1);
    chk("cx_data", 64'(bus.out_data), 64'h0000_0000);
    chk("cx_count", 64'(bus.out_count), 64'd2);
    tick();

    // single element, back-pressured result
    bus.out_ready = 1'b0;
    send(32'h4120_0000, 1'b1, 1'b0);
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", 64'(bus.out_data), 64'h4120_0000);
      chk("bp_count", 64'(bus.out_count), 64'd1);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);

    // reset during ADD
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    chk("mr_in_add", 64'(bus.add_b), 64'h4000_0000);
    rst = 1'b1;
    #1;
    chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mr_add_a", 64'(bus.add_a), 64'd0);
    chk("mr_add_b", 64'(bus.add_b), 64'd0);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_data", 64'(bus.out_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send(32'h3F80_0000, 1'b1, 1'b0);
    wait_out(lat);
    chk("mr_latency", 64'(lat), 64'd0);
    chk("mr_data", 64'(bus.out_data), 64'h3F80_0000);
    chk("mr_count", 64'(bus.out_count), 64'd1);
    tick();
    chk("mr_done", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
